// File: rtl/data_mem_mmio_pkg.sv
// Shared constants for the data memory / machine-timer block: access types, regions, MMIO map.
// Pure definitions; no timing or flow-control content.
package data_mem_pkg;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  localparam logic [3:0] REGION_RAM  = 4'h0;
  localparam logic [3:0] REGION_MMIO = 4'h1;

  localparam logic [2:0] MMIO_MTIME_LO    = 3'd0;
  localparam logic [2:0] MMIO_MTIME_HI    = 3'd1;
  localparam logic [2:0] MMIO_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MMIO_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] MMIO_CTRL        = 3'd4;
  localparam logic [2:0] MMIO_STATUS      = 3'd5;

  localparam int CTRL_CNT_EN = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {ACC_B, ACC_H, ACC_W} acc_size_e;

  // Unlisted func3 codes fall back to a full-word access.
  function automatic acc_size_e acc_size(input logic [2:0] rw_type);
    case (rw_type)
      RW_B, RW_BU: return ACC_B;
      RW_H, RW_HU: return ACC_H;
      RW_W:        return ACC_W;
      default:     return ACC_W;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_mmio_if.sv
// MEM-stage to data-memory bus: request/store data from master, load data and status from slave.
// No handshake: the slave accepts every request in the cycle it is presented.
interface data_mem_mmio_if;
  logic        R_en;
  logic        W_en;
  logic [2:0]  RW_type;
  logic [31:0] ram_addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        timer_irq;
  logic        misalign_err;

  modport master (
    output R_en, W_en, RW_type, ram_addr, store_data,
    input  load_data, timer_irq, misalign_err
  );

  modport slave (
    input  R_en, W_en, RW_type, ram_addr, store_data,
    output load_data, timer_irq, misalign_err
  );
endinterface

// File: rtl/data_mem_mmio_mtimer.sv
// Machine timer: 64-bit mtime with prescaler, mtimecmp, ctrl and a registered irq.
// Reads are combinational, writes and irq update on the rising edge; never stalls.
module mtimer
  import data_mem_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en_i,
  input  logic [2:0]  off_i,
  input  logic [31:0] wr_dat_i,
  output logic [31:0] rd_dat_o,
  output logic        irq_o
);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     cmp_q, cmp_d;
  logic [1:0]      ctrl_q, ctrl_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic            irq_q;
  logic            due;

  assign due = (mtime_q >= cmp_q);

  // A software write to either mtime half overrides the tick and restarts the prescaler.
  always_comb begin
    mtime_d = mtime_q;
    cmp_d   = cmp_q;
    ctrl_d  = ctrl_q;
    ps_d    = ps_q;
    if (ctrl_q[CTRL_CNT_EN]) begin
      if (ps_q == PS_LAST) begin
        ps_d    = '0;
        mtime_d = mtime_q + 64'd1;
      end else begin
        ps_d = ps_q + 1'b1;
      end
    end
    if (wr_en_i) begin
      case (off_i)
        MMIO_MTIME_LO:    begin mtime_d = {mtime_q[63:32], wr_dat_i}; ps_d = '0; end
        MMIO_MTIME_HI:    begin mtime_d = {wr_dat_i, mtime_q[31:0]};  ps_d = '0; end
        MMIO_MTIMECMP_LO: cmp_d  = {cmp_q[63:32], wr_dat_i};
        MMIO_MTIMECMP_HI: cmp_d  = {wr_dat_i, cmp_q[31:0]};
        MMIO_CTRL:        ctrl_d = wr_dat_i[1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q <= '0;
      cmp_q   <= '1;
      ctrl_q  <= '0;
      ps_q    <= '0;
      irq_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
      ps_q    <= ps_d;
      irq_q   <= ctrl_q[CTRL_IRQ_EN] & due;
    end
  end

  always_comb begin
    case (off_i)
      MMIO_MTIME_LO:    rd_dat_o = mtime_q[31:0];
      MMIO_MTIME_HI:    rd_dat_o = mtime_q[63:32];
      MMIO_MTIMECMP_LO: rd_dat_o = cmp_q[31:0];
      MMIO_MTIMECMP_HI: rd_dat_o = cmp_q[63:32];
      MMIO_CTRL:        rd_dat_o = {30'b0, ctrl_q};
      MMIO_STATUS:      rd_dat_o = {31'b0, due};
      default:          rd_dat_o = '0;
    endcase
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/data_mem_mmio.sv
// Data RAM with B/H/W stores and extending loads, plus timer MMIO; DATA_MEM_MISALIGN_CHECK_EN traps misalignment.
// Loads zero-cycle combinational, stores commit on the rising edge; always ready, no backpressure.
module data_mem_mmio
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int PRESCALE    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_mmio_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  acc_size_e     size;
  logic [3:0]    region;
  logic          access_ok;
  logic [31:0]   eff_addr;
  logic [AW-1:0] word_idx;
  logic [3:0]    byte_en;
  logic [31:0]   wr_word;
  logic          ram_we;
  logic          mmio_we;
  logic [31:0]   mmio_rd_dat;
  logic [31:0]   rd_word;
  logic [15:0]   lane_dat;
  logic [31:0]   ext_dat;
  logic          timer_irq;
  logic          unused_addr;

  assign size   = acc_size(bus.RW_type);
  assign region = bus.ram_addr[31:28];

`ifdef DATA_MEM_MISALIGN_CHECK_EN
  logic misaligned;
  logic misalign_q;

  assign misaligned = ((size == ACC_H) && bus.ram_addr[0]) ||
                      ((size == ACC_W) && (bus.ram_addr[1:0] != 2'b00));
  assign access_ok  = !misaligned;
  assign eff_addr   = bus.ram_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      misalign_q <= 1'b0;
    else if ((bus.R_en || bus.W_en) && misaligned)
      misalign_q <= 1'b1;
  end
  assign bus.misalign_err = misalign_q;
`else
  assign access_ok = 1'b1;
  always_comb begin
    eff_addr = bus.ram_addr;
    if (size == ACC_H) eff_addr[0]   = 1'b0;
    if (size == ACC_W) eff_addr[1:0] = 2'b00;
  end
  assign bus.misalign_err = 1'b0;
`endif

  assign word_idx    = eff_addr[AW+1:2];
  assign unused_addr = ^eff_addr;
  assign ram_we      = bus.W_en && access_ok && (region == REGION_RAM);
  assign mmio_we     = bus.W_en && access_ok && (region == REGION_MMIO);

  always_comb begin
    byte_en = 4'b1111;
    wr_word = bus.store_data;
    case (size)
      ACC_B: begin
        byte_en = 4'b0001 << eff_addr[1:0];
        wr_word = {4{bus.store_data[7:0]}};
      end
      ACC_H: begin
        byte_en = eff_addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{bus.store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // rst_n gate drops a store that coincides with reset.
  always_ff @(posedge clk) begin
    if (rst_n && ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  mtimer #(.PRESCALE(PRESCALE)) u_mtimer (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (mmio_we),
    .off_i    (eff_addr[4:2]),
    .wr_dat_i (bus.store_data),
    .rd_dat_o (mmio_rd_dat),
    .irq_o    (timer_irq)
  );
  assign bus.timer_irq = timer_irq;

  always_comb begin
    case (region)
      REGION_RAM:  rd_word = mem[word_idx];
      REGION_MMIO: rd_word = mmio_rd_dat;
      default:     rd_word = '0;
    endcase
    lane_dat = 16'(rd_word >> {eff_addr[1:0], 3'b000});
    case (size)
      ACC_B:   ext_dat = bus.RW_type[2] ? {24'b0, lane_dat[7:0]}
                                        : {{24{lane_dat[7]}}, lane_dat[7:0]};
      ACC_H:   ext_dat = bus.RW_type[2] ? {16'b0, lane_dat}
                                        : {{16{lane_dat[15]}}, lane_dat};
      default: ext_dat = rd_word;
    endcase
  end

  assign bus.load_data = (bus.R_en && !bus.W_en && access_ok) ? ext_dat : '0;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Randomized bench for data_mem_mmio against a byte-array / integer-timer reference model.
module tb_data_mem_mmio;
  localparam int DEPTH = 64;
  localparam int PS    = 1;
  localparam logic [2:0] T_B = 3'b000, T_H = 3'b001, T_W = 3'b010, T_BU = 3'b100, T_HU = 3'b101;
  localparam logic [31:0] MT_LO = 32'h1000_0000, MT_HI = 32'h1000_0004;
  localparam logic [31:0] CMP_LO = 32'h1000_0008, CMP_HI = 32'h1000_000C, CTRL = 32'h1000_0010;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  data_mem_mmio_if mem_bus ();
  data_mem_mmio #(.DEPTH_WORDS(DEPTH), .PRESCALE(PS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mem_bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [7:0]  m_ram [DEPTH*4];
  logic [63:0] m_mtime, m_cmp;
  logic [1:0]  m_ctrl;
  int          m_ps;
  logic        m_irq, m_mis;

  task automatic m_reset();
    m_mtime = '0; m_cmp = '1; m_ctrl = '0; m_ps = 0; m_irq = 1'b0; m_mis = 1'b0;
  endtask

  function automatic int nbytes(input logic [2:0] t);
    case (t)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit is_mis(input logic [2:0] t, input logic [31:0] a);
    return (int'(a[1:0]) % nbytes(t)) != 0;
  endfunction

  function automatic bit acc_ok(input logic [2:0] t, input logic [31:0] a);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    return !is_mis(t, a);
`else
    return (t == t) && (a == a);
`endif
  endfunction

  function automatic logic [31:0] align(input logic [2:0] t, input logic [31:0] a);
    return a - 32'(int'(a[1:0]) % nbytes(t));
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] ea);
    int base;
    if (ea[31:28] == 4'h0) begin
      base = (int'(ea[31:2]) % DEPTH) * 4;
      return {m_ram[base+3], m_ram[base+2], m_ram[base+1], m_ram[base]};
    end
    if (ea[31:28] == 4'h1) begin
      case (ea[4:2])
        3'd0: return m_mtime[31:0];
        3'd1: return m_mtime[63:32];
        3'd2: return m_cmp[31:0];
        3'd3: return m_cmp[63:32];
        3'd4: return {30'b0, m_ctrl};
        3'd5: return {31'b0, m_mtime >= m_cmp};
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_load(input logic r, input logic w, input logic [2:0] t,
                                         input logic [31:0] a);
    logic [31:0] ea, word, v;
    int n;
    if (!r || w || !acc_ok(t, a)) return 32'h0;
    n    = nbytes(t);
    ea   = align(t, a);
    word = m_word(ea);
    v    = word >> (8 * int'(ea[1:0]));
    if (n == 1) begin
      v = v & 32'hFF;
      if (!t[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (n == 2) begin
      v = v & 32'hFFFF;
      if (!t[2] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  task automatic m_step(input logic r, input logic w, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d);
    logic [31:0] ea;
    logic [63:0] nt;
    logic        nirq;
    int          nps, n, base;
    n    = nbytes(t);
    ea   = align(t, a);
    nirq = m_ctrl[1] && (m_mtime >= m_cmp);
    nt   = m_mtime;
    nps  = m_ps;
    if (m_ctrl[0]) begin
      if (m_ps == PS - 1) begin nps = 0; nt = m_mtime + 64'd1; end
      else nps = m_ps + 1;
    end
    if (w && acc_ok(t, a)) begin
      if (ea[31:28] == 4'h0) begin
        base = (int'(ea[31:2]) % DEPTH) * 4 + int'(ea[1:0]);
        for (int i = 0; i < n; i++) m_ram[base + i] = d[8*i +: 8];
      end else if (ea[31:28] == 4'h1) begin
        case (ea[4:2])
          3'd0: begin nt = {m_mtime[63:32], d}; nps = 0; end
          3'd1: begin nt = {d, m_mtime[31:0]}; nps = 0; end
          3'd2: m_cmp = {m_cmp[63:32], d};
          3'd3: m_cmp = {d, m_cmp[31:0]};
          3'd4: m_ctrl = d[1:0];
          default: ;
        endcase
      end
    end
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    if ((r || w) && is_mis(t, a)) m_mis = 1'b1;
`endif
    m_mtime = nt;
    m_ps    = nps;
    m_irq   = nirq;
  endtask

  // One bus cycle: drive at negedge, sample before the edge, advance the model at the edge.
  task automatic cyc(input logic r, input logic w, input logic [2:0] t, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] ld);
    mem_bus.R_en = r; mem_bus.W_en = w; mem_bus.RW_type = t;
    mem_bus.ram_addr = a; mem_bus.store_data = d;
    #1;
    ld = mem_bus.load_data;
    check_eq("load_data", ld, m_load(r, w, t, a));
    check_eq("timer_irq", {31'b0, mem_bus.timer_irq}, {31'b0, m_irq});
    check_eq("misalign_err", {31'b0, mem_bus.misalign_err}, {31'b0, m_mis});
    @(posedge clk);
    m_step(r, w, t, a, d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    mem_bus.R_en = 1'b0; mem_bus.W_en = 1'b1; mem_bus.RW_type = T_W;
    mem_bus.ram_addr = 32'h0; mem_bus.store_data = 32'hDEAD_BEEF;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_irq", {31'b0, mem_bus.timer_irq}, 32'h0);
    check_eq("rst_misalign", {31'b0, mem_bus.misalign_err}, 32'h0);
    @(negedge clk);
    mem_bus.W_en = 1'b0;
    rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ld, a, d;
    logic [2:0]  t;
    logic        r, w;
    mem_bus.R_en = 1'b0; mem_bus.W_en = 1'b0; mem_bus.RW_type = '0;
    mem_bus.ram_addr = '0; mem_bus.store_data = '0;
    @(negedge clk);
    do_reset();
    check_eq("rst_load", mem_bus.load_data, 32'h0);
    cyc(1, 0, T_W, MT_LO, 0, ld);   check_eq("rst_mtime_lo", ld, 32'h0);
    cyc(1, 0, T_W, CMP_HI, 0, ld);  check_eq("rst_cmp_hi", ld, 32'hFFFF_FFFF);
    cyc(1, 0, T_W, CTRL, 0, ld);    check_eq("rst_ctrl", ld, 32'h0);

    for (int i = 0; i < DEPTH; i++) cyc(0, 1, T_W, 32'(i * 4), $urandom, ld);

    cyc(0, 1, T_W, 32'h10, 32'h8765_4321, ld);
    cyc(1, 0, T_B,  32'h13, 0, ld); check_eq("lb_13",  ld, 32'hFFFF_FF87);
    cyc(1, 0, T_BU, 32'h13, 0, ld); check_eq("lbu_13", ld, 32'h0000_0087);
    cyc(1, 0, T_H,  32'h12, 0, ld); check_eq("lh_12",  ld, 32'hFFFF_8765);
    cyc(1, 0, T_HU, 32'h10, 0, ld); check_eq("lhu_10", ld, 32'h0000_4321);
    cyc(1, 0, T_W,  32'h10, 0, ld); check_eq("lw_10",  ld, 32'h8765_4321);
    cyc(0, 1, T_B,  32'h11, 32'h0000_00AA, ld);
    cyc(1, 0, T_W,  32'h10, 0, ld); check_eq("sb_merge", ld, 32'h8765_AA21);

    cyc(0, 1, T_W, MT_LO, 32'hFFFF_FFFE, ld);
    cyc(0, 1, T_W, CTRL, 32'h1, ld);
    cyc(0, 0, T_W, 0, 0, ld);
    cyc(0, 1, T_W, CTRL, 32'h0, ld);
    cyc(1, 0, T_W, MT_HI, 0, ld); check_eq("wrap_hi", ld, 32'h1);
    cyc(1, 0, T_W, MT_LO, 0, ld); check_eq("wrap_lo", ld, 32'h0);

    cyc(0, 1, T_W, MT_LO, 0, ld);
    cyc(0, 1, T_W, MT_HI, 0, ld);
    cyc(0, 1, T_W, CMP_LO, 5, ld);
    cyc(0, 1, T_W, CMP_HI, 0, ld);
    cyc(0, 1, T_W, CTRL, 3, ld);
    repeat (5) cyc(0, 0, T_W, 0, 0, ld);
    check_eq("irq_before", {31'b0, mem_bus.timer_irq}, 32'h0);
    cyc(0, 0, T_W, 0, 0, ld);
    check_eq("irq_rise", {31'b0, mem_bus.timer_irq}, 32'h1);
    cyc(0, 1, T_W, CMP_HI, 1, ld);
    check_eq("irq_hold", {31'b0, mem_bus.timer_irq}, 32'h1);
    cyc(0, 0, T_W, 0, 0, ld);
    check_eq("irq_drop", {31'b0, mem_bus.timer_irq}, 32'h0);
    cyc(0, 1, T_W, CTRL, 0, ld);

    cyc(1, 0, T_W, 32'h2000_0000, 0, ld); check_eq("unmapped_ld", ld, 32'h0);
    cyc(0, 1, T_W, 32'h2000_0010, 32'h5555_5555, ld);
    cyc(1, 0, T_W, 32'h10, 0, ld); check_eq("unmapped_st", ld, 32'h8765_AA21);
    cyc(1, 1, T_W, 32'h14, 32'h1234_5678, ld); check_eq("rw_both_ld", ld, 32'h0);
    cyc(1, 0, T_W, 32'h14, 0, ld); check_eq("rw_both_st", ld, 32'h1234_5678);

    cyc(0, 1, T_W, 32'h0, 32'h1122_3344, ld);
    cyc(0, 1, T_W, 32'h2, 32'hCAFE_F00D, ld);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    cyc(1, 0, T_W, 32'h0, 0, ld); check_eq("mis_suppress", ld, 32'h1122_3344);
    check_eq("mis_flag", {31'b0, mem_bus.misalign_err}, 32'h1);
`else
    cyc(1, 0, T_W, 32'h0, 0, ld); check_eq("mis_align", ld, 32'hCAFE_F00D);
    check_eq("mis_flag", {31'b0, mem_bus.misalign_err}, 32'h0);
`endif
    do_reset();
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    cyc(1, 0, T_W, 32'h0, 0, ld); check_eq("rst_store_lost", ld, 32'h1122_3344);
`else
    cyc(1, 0, T_W, 32'h0, 0, ld); check_eq("rst_store_lost", ld, 32'hCAFE_F00D);
`endif
    cyc(1, 0, T_W, CMP_LO, 0, ld); check_eq("rst2_cmp_lo", ld, 32'hFFFF_FFFF);

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = $urandom & 32'h0FFF_FFFF;
        6, 7, 8:          a = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFF);
        default:          a = {4'($urandom_range(2, 15)), 28'($urandom)};
      endcase
      t = 3'($urandom_range(0, 7));
      r = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      cyc(r, w, t, a, d, ld);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Data-side memory block sitting directly downstream of the pipeline's MEM stage. It consumes `R_en`, `W_en`, `RW_type`, `ram_addr` and `store_data`, and returns `load_data` in the same cycle. It contains a word-organised data RAM with byte/half/word access and load sign/zero extension, plus a small memory-mapped machine-timer region that raises `timer_irq`. Stores commit on the clock edge; loads are combinational so the MEM stage sees data without a stall.

## Interface

Parameters:
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words; must be a power of two.
- `PRESCALE`, default 1: clock cycles per `mtime` increment; must be ≥1.

Ports:
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `R_en` input 1: load request, from the EX/MEM register.
- `W_en` input 1: store request.
- `RW_type` input 3: access type, equal to func3. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `ram_addr` input 32: byte address.
- `store_data` input 32: store data, LSB-aligned.
- `load_data` output 32: extended load result.
- `timer_irq` output 1: registered timer interrupt.
- `misalign_err` output 1: sticky misaligned-access flag.

## Operation

Address decode on `ram_addr[31:28]`:
- 0x0: RAM, word index `ram_addr[log2(DEPTH_WORDS)+1:2]`; upper bits ignored (aliasing).
- 0x1: MMIO, offset `ram_addr[4:2]`.
- Anything else: unmapped. Loads return 0; stores are ignored.

RAM access:
- Little-endian.
- SB writes byte lane `addr[1:0]`; SH writes lanes {`addr[1]`\*2+1 : `addr[1]`\*2}; SW writes all four lanes.
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `RW_type` codes 011, 110 and 111 are treated as W.

MMIO registers:
- All are 32-bit. Sub-word MMIO stores write the full register with `store_data`.
- 0x00 `mtime_lo`, 0x04 `mtime_hi`: 64-bit counter.
- 0x08 `mtimecmp_lo`, 0x0C `mtimecmp_hi`.
- 0x10 `ctrl`: bit0 count enable, bit1 irq enable; other bits read 0.
- 0x14 `status`: bit0 = `mtime >= mtimecmp` (read-only).
- Offsets 0x18 and 0x1C read 0; writes are ignored.

Timer:
- The prescale counter runs only while `ctrl[0]` is set.
- `mtime` increments by 1 when the prescale counter reaches `PRESCALE-1`; the prescale counter then wraps to 0.
- Carry from lo to hi is a full 64-bit add; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- A store to `mtime_lo` or `mtime_hi` wins over the increment in that cycle: only the written half changes, the other half holds, and the prescale counter clears.

Simultaneous and out-of-range requests:
- `R_en` and `W_en` both high: the store is performed and `load_data` is 0.
- `R_en` low: `load_data` is 0.

## Timing

- `load_data` is combinational from `R_en`, `RW_type`, `ram_addr` and the stored state (zero-cycle latency).
- A store commits at the rising edge where `W_en` is 1. A load in the following cycle returns the new value.
- A load in the same cycle as a store returns the old value.
- `timer_irq` is a register: `ctrl[1] & (mtime >= mtimecmp)` evaluated on the previous cycle's state. It therefore deasserts one cycle after a `mtimecmp` write that clears the condition.
- Reset values:
  - `mtime` = 0, prescale counter = 0.
  - `mtimecmp` = 0xFFFF_FFFF_FFFF_FFFF.
  - `ctrl` = 0.
  - `timer_irq` = 0, `misalign_err` = 0.
  - RAM contents are not reset.
- Asserting `rst_n` during an in-flight store: the store is lost and registers take their reset values immediately.

## Configuration

Macro `DATA_MEM_MISALIGN_CHECK_EN`.

Defined:
- A misaligned access (H/HU with `addr[0]`=1, W with `addr[1:0]`≠0) sets `misalign_err` at the next edge. The flag stays set until reset.
- A misaligned store is suppressed.
- A misaligned load returns 0.

Undefined:
- The offending low address bits are forced to 0, and the access proceeds aligned.
- `misalign_err` is tied to 0.

## Structure

- Package `data_mem_pkg` holds:
  - `RW_type` localparams (B, H, W, BU, HU).
  - Region codes (RAM 0x0, MMIO 0x1).
  - MMIO offset constants.
  - `ctrl` bit positions.
- Sub-module `mtimer` contains `mtime`, `mtimecmp`, `ctrl`, the prescaler and the `timer_irq` register. Its inputs are a write strobe, offset and data; its outputs are read data and irq.
- The top level keeps the decode logic, the RAM array, the lane/extension logic and the misalign logic.

## Test plan

- SW 0x8765_4321 to 0x0000_0010, then LB/LBU/LH/LHU/LW at 0x10..0x13:
  - LB 0x13 → 0xFFFF_FF87; LBU 0x13 → 0x87.
  - LH 0x12 → 0xFFFF_8765; LHU 0x10 → 0x4321.
  - LW 0x10 → 0x8765_4321.
- SB 0xAA to 0x11 over word 0x8765_4321 → LW 0x10 returns 0x8765_AA21. A load in the same cycle as the store returns the old word.
- Write `mtime_lo`=0xFFFF_FFFE, `ctrl`=1 with `PRESCALE`=1. Two cycles later `mtime_hi`=1 and `mtime_lo`=0.
- Write `mtimecmp`=5, `ctrl`=3 → `timer_irq` rises on the edge after `mtime` reaches 5. A write of `mtimecmp_hi`=1 drops it one cycle later.
- LW at 0x2000_0000 → 0; SW there leaves all RAM and MMIO unchanged; `R_en`&`W_en` both high → `load_data`=0 and the store is performed.
- With `DATA_MEM_MISALIGN_CHECK_EN`, SW to 0x02 → memory unchanged and `misalign_err`=1 until `rst_n` pulses low. Without the macro, the same store writes word 0x00.
